tick_countdown_timer: RTL and testbench

- BCD mm:ss countdown timer clocked by the system clock `CLK`.
- Consumes the slow square wave produced by the clock divider as a plain data input, not as a clock.
- Rising edges of that wave are converted to single-cycle enables and prescaled to one-second decrements.
- Feeds the 7-segment display driver (time digits) and game control logic (RUNNING, DONE, EXPIRED).

---
 rtl/tick_countdown_timer.sv | 80 ++++++++
 tb/tb_tick_countdown_timer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tick_countdown_timer.sv
// tick_countdown_timer: BCD mm:ss countdown driven by rising edges of a slow wave sampled in the clk domain.
module tick_countdown_timer #(
    parameter int TICKS_PER_SEC = 25
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_slow_clk,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_start,
    input  logic        i_pause,
    output logic [15:0] o_time_bcd,
    output logic        o_running,
    output logic        o_done,
    output logic        o_expired
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;
    state_t      r_state, w_next;
    logic        r_slow_q, r_running, r_done, r_expired;
    logic [7:0]  r_sub_cnt;
    logic [15:0] r_time_bcd, w_san, w_dec;
    logic        w_tick, w_count, w_sec_end, w_expire, w_nonzero;
    logic        w_b_s, w_b_t, w_b_m;
    logic [3:0]  w_so, w_st, w_mo, w_mt;
    assign w_tick    = i_slow_clk & ~r_slow_q;
    assign w_nonzero = r_time_bcd != 16'h0000;
    // PAUSE always acts in RUN and START is ignored there, so only LOAD/PAUSE block counting
    assign w_count   = (r_state == S_RUN) & ~i_load & ~i_pause & w_tick;
    assign w_sec_end = w_count & (r_sub_cnt == 8'(TICKS_PER_SEC - 1));
    assign w_expire  = w_sec_end & (r_time_bcd == 16'h0001);
    assign {w_mt, w_mo, w_st, w_so} = r_time_bcd;
    assign w_b_s = w_so == 4'd0;
    assign w_b_t = w_b_s & (w_st == 4'd0);
    assign w_b_m = w_b_t & (w_mo == 4'd0);
    assign w_dec = {w_b_m ? w_mt - 4'd1 : w_mt,
                    w_b_t ? (w_mo == 4'd0 ? 4'd9 : w_mo - 4'd1) : w_mo,
                    w_b_s ? (w_st == 4'd0 ? 4'd5 : w_st - 4'd1) : w_st,
                    w_b_s ? 4'd9 : w_so - 4'd1};
    assign w_san = {i_load_val[15:12] > 4'd9 ? 4'd9 : i_load_val[15:12],
                    i_load_val[11:8]  > 4'd9 ? 4'd9 : i_load_val[11:8],
                    i_load_val[7:4]   > 4'd5 ? 4'd5 : i_load_val[7:4],
                    i_load_val[3:0]   > 4'd9 ? 4'd9 : i_load_val[3:0]};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_slow_q   <= 1'b0;
            r_sub_cnt  <= 8'd0;
            r_time_bcd <= 16'h0000;
        end else begin
            r_state    <= w_next;
            r_slow_q   <= i_slow_clk;
            r_sub_cnt  <= (i_load | w_sec_end) ? 8'd0 : w_count ? r_sub_cnt + 8'd1 : r_sub_cnt;
            r_time_bcd <= i_load ? w_san : (w_sec_end & w_nonzero) ? w_dec : r_time_bcd;
        end
    end
    always_comb begin
        w_next = r_state;
        if (i_load)
            w_next = S_IDLE;
        else if (r_state == S_RUN)
            w_next = i_pause ? S_PAUSED : w_expire ? S_DONE : S_RUN;
        else if (i_start & ~i_pause & ((r_state == S_IDLE & w_nonzero) | r_state == S_PAUSED))
            w_next = S_RUN;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_running <= w_next == S_RUN;
            r_done    <= w_next == S_DONE;
            r_expired <= w_expire;
        end
    end
    assign o_time_bcd = r_time_bcd;
    assign o_running  = r_running;
    assign o_done     = r_done;
    assign o_expired  = r_expired;
endmodule

// File: tb/tb_tick_countdown_timer.sv
// tb_tick_countdown_timer: randomized + directed stimulus against a seconds-count model via a scoreboard queue.
module tb_tick_countdown_timer;
    localparam int T = 2;
    logic        clk = 0, rst_n = 0, slow = 0, load = 0, start = 0, pause = 0;
    logic [15:0] lval = 0, t_bcd;
    logic        running, done, expired;
    typedef struct packed {logic [15:0] t; logic r; logic d; logic e;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0, wc = 0;
    int m_state, m_secs, m_sub;
    bit m_slow_q, m_exp;

    tick_countdown_timer #(.TICKS_PER_SEC(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_slow_clk(slow), .i_load(load), .i_load_val(lval),
        .i_start(start), .i_pause(pause), .o_time_bcd(t_bcd), .o_running(running),
        .o_done(done), .o_expired(expired));

    always #5 clk = ~clk;

    function automatic int min9(int x, int lim);
        return x > lim ? lim : x;
    endfunction

    function automatic int san_secs(logic [15:0] v);
        return (min9(int'(v[15:12]), 9) * 10 + min9(int'(v[11:8]), 9)) * 60
             + min9(int'(v[7:4]), 5) * 10 + min9(int'(v[3:0]), 9);
    endfunction

    function automatic logic [15:0] to_bcd(int s);
        int m = s / 60, x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic chk(string n, logic [15:0] a, logic [15:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
        end
    endtask

    function automatic void push_exp();
        q.push_back(exp_t'{to_bcd(m_secs), m_state == 1, m_state == 3, m_exp});
    endfunction

    function automatic void model_reset();
        m_state = 0; m_secs = 0; m_sub = 0; m_slow_q = 0; m_exp = 0;
    endfunction

    // state codes in the model: 0 idle, 1 run, 2 paused, 3 done
    task automatic step(bit ld, logic [15:0] v, bit st, bit pa, bit sl);
        bit tick;
        @(negedge clk);
        rst_n = 1; load = ld; lval = v; start = st; pause = pa; slow = sl;
        tick = sl & !m_slow_q;
        m_exp = 0;
        if (ld) begin
            m_secs = san_secs(v); m_sub = 0; m_state = 0;
        end else if (pa) begin
            if (m_state == 1) m_state = 2;
        end else if (st && ((m_state == 0 && m_secs > 0) || m_state == 2)) begin
            m_state = 1;
        end else if (m_state == 1 && tick) begin
            m_sub++;
            if (m_sub == T) begin
                m_sub = 0;
                m_secs--;
                if (m_secs == 0) begin m_state = 3; m_exp = 1; end
            end
        end
        m_slow_q = sl;
        push_exp();
    endtask

    task automatic cyc(bit ld = 0, logic [15:0] v = 0, bit st = 0, bit pa = 0);
        step(ld, v, st, pa, wc[2]);
        wc++;
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0; load = 0; start = 0; pause = 0;
        #1;
        chk("rst_time", t_bcd, 16'h0000);
        chk("rst_running", 16'(running), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_expired", 16'(expired), 16'h0);
        model_reset();
        push_exp();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("time", t_bcd, e.t);
                chk("running", 16'(running), 16'(e.r));
                chk("done", 16'(done), 16'(e.d));
                chk("expired", 16'(expired), 16'(e.e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int hold;
        bit sl;
        model_reset();
        do_reset();
        cyc(1, 16'h0130); cyc(0, 0, 1); idle(20); do_reset();
        cyc(1, 16'h0003); cyc(0, 0, 1); idle(60);
        cyc(1, 16'h0100); cyc(0, 0, 1); idle(16); cyc(0, 0, 0, 1); idle(80); cyc(0, 0, 1); idle(20);
        cyc(1, 16'hAB7F); idle(3); cyc(1, 16'h0000); cyc(0, 0, 1); idle(3);
        cyc(1, 16'h0010); cyc(0, 0, 1); idle(5); cyc(0, 0, 1, 1); idle(5);
        cyc(1, 16'h0020, 1); idle(3);
        cyc(1, 16'h0001);
        while (wc % 8 != 4) cyc();
        cyc(0, 0, 1); idle(30);
        hold = 0; sl = 0;
        for (int i = 0; i < 2500; i++) begin
            bit ld, st, pa;
            logic [15:0] v;
            if (hold == 0) begin sl = !sl; hold = $urandom_range(1, 6); end
            hold--;
            ld = $urandom_range(0, 39) == 0;
            st = $urandom_range(0, 7) == 0;
            pa = $urandom_range(0, 29) == 0;
            v  = $urandom_range(0, 1) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(ld, v, st, pa, sl);
        end
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
